// File: rtl/strela_ctrl_reg_pkg.sv
// strela_ctrl_reg_pkg: register map, bit indices, bus structs and state enum for strela_ctrl_regs
package strela_ctrl_reg_pkg;

    localparam logic [4:0] CTRL_OFFS      = 5'h00;
    localparam logic [4:0] STATUS_OFFS    = 5'h04;
    localparam logic [4:0] IN_ADDR_OFFS   = 5'h08;
    localparam logic [4:0] IN_SIZE_OFFS   = 5'h0C;
    localparam logic [4:0] OUT_ADDR_OFFS  = 5'h10;
    localparam logic [4:0] OUT_SIZE_OFFS  = 5'h14;
    localparam logic [4:0] CYCLE_CNT_OFFS = 5'h18;
    localparam logic [4:0] ID_OFFS        = 5'h1C;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 2;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h5354_0001;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_s;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_s;

    typedef enum logic {IDLE, RUN} ctrl_state_e;

    // Merge write data into an existing value byte by byte.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] wd,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (strb[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/strela_sat_counter.sv
// strela_sat_counter: 32-bit up counter with synchronous clear, enable and saturation
// Ports: clk_i, rst_ni (async active-low), clr_i (clear, wins over enable), en_i (count), cnt_o (value)
module strela_sat_counter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [31:0] cnt_o
);
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_o <= '0;
        else cnt_o <= clr_i ? '0 : (en_i && !(&cnt_o)) ? cnt_o + 32'd1 : cnt_o;
endmodule

// File: rtl/strela_ctrl_regs.sv
// strela_ctrl_regs: STRELA config registers with start/busy/done handshake on reg_bus (one wait state)
// Ports: clk_i, rst_ni (async active-low), reg_req_i/reg_rsp_o (reg_bus), start_o/done_i/busy_o (fabric
// handshake), in_addr_o/in_size_o/out_addr_o/out_size_o (config), irq_o (DONE & IRQ_EN, registered).
// Macro STRELA_CTRL_PERF_EN enables the CYCLE_CNT busy-cycle counter; otherwise CYCLE_CNT reads 0.
module strela_ctrl_regs
    import strela_ctrl_reg_pkg::*;
#(
    parameter type         reg_req_t = reg_req_s,
    parameter type         reg_rsp_t = reg_rsp_s,
    parameter logic [31:0] ID_VALUE  = ID_VALUE_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  reg_req_t    reg_req_i,
    output reg_rsp_t    reg_rsp_o,
    output logic        start_o,
    input  logic        done_i,
    output logic        busy_o,
    output logic [31:0] in_addr_o,
    output logic [31:0] in_size_o,
    output logic [31:0] out_addr_o,
    output logic [31:0] out_size_o,
    output logic        irq_o
);
    ctrl_state_e state;
    logic        ready_q, err_q, start_q, irq_q, irq_en_q, done_q;
    logic [31:0] rdata_q, in_addr_q, in_size_q, out_addr_q, out_size_q, cycle_cnt, rd_val, wmask;
    logic [4:0]  offs;
    logic        acc, err, ok_wr, go, fin, w1c, status_bad, unused;

    assign unused = ^reg_req_i.addr[1:0];
    assign offs   = {reg_req_i.addr[4:2], 2'b00};
    // A held valid is taken once; the cycle that presents ready does not re-sample.
    assign acc    = reg_req_i.valid & ~ready_q;
    assign wmask  = {{8{reg_req_i.wstrb[3]}}, {8{reg_req_i.wstrb[2]}},
                     {8{reg_req_i.wstrb[1]}}, {8{reg_req_i.wstrb[0]}}};
    assign status_bad = |(reg_req_i.wdata & wmask & ~(32'h1 << STATUS_DONE_BIT));
    assign err    = acc & ((|reg_req_i.addr[31:5]) |
                           (reg_req_i.write & ((offs == STATUS_OFFS && status_bad) ||
                                               offs == CYCLE_CNT_OFFS || offs == ID_OFFS)));
    assign ok_wr  = acc & reg_req_i.write & ~err;
    assign go     = ok_wr && offs == CTRL_OFFS && reg_req_i.wstrb[0] &&
                    reg_req_i.wdata[CTRL_START_BIT] && state == IDLE;
    assign fin    = state == RUN && done_i;
    assign w1c    = ok_wr && offs == STATUS_OFFS && reg_req_i.wstrb[0] && reg_req_i.wdata[STATUS_DONE_BIT];

`ifdef STRELA_CTRL_PERF_EN
    // The cycle that sees done_i leaves RUN and is not counted.
    strela_sat_counter u_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (go),
        .en_i   (state == RUN && !done_i),
        .cnt_o  (cycle_cnt)
    );
`else
    assign cycle_cnt = '0;
`endif

    always_comb begin
        rd_val = '0;
        case (offs)
            CTRL_OFFS:      rd_val[CTRL_IRQ_EN_BIT] = irq_en_q;
            STATUS_OFFS:    rd_val = {30'b0, done_q, state == RUN};
            IN_ADDR_OFFS:   rd_val = in_addr_q;
            IN_SIZE_OFFS:   rd_val = in_size_q;
            OUT_ADDR_OFFS:  rd_val = out_addr_q;
            OUT_SIZE_OFFS:  rd_val = out_size_q;
            CYCLE_CNT_OFFS: rd_val = cycle_cnt;
            default:        rd_val = ID_VALUE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            start_q    <= 1'b0;
            irq_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            in_addr_q  <= '0;
            in_size_q  <= '0;
            out_addr_q <= '0;
            out_size_q <= '0;
        end else begin
            ready_q <= acc;
            err_q   <= err;
            rdata_q <= (acc && !err && !reg_req_i.write) ? rd_val : '0;
            start_q <= go;
            irq_q   <= done_q & irq_en_q;
            state   <= go ? RUN : fin ? IDLE : state;
            // done_i set wins over a simultaneous W1C.
            done_q  <= fin | (done_q & ~go & ~w1c);
            if (ok_wr && offs == CTRL_OFFS && reg_req_i.wstrb[0]) irq_en_q <= reg_req_i.wdata[CTRL_IRQ_EN_BIT];
            if (ok_wr && offs == IN_ADDR_OFFS)  in_addr_q  <= apply_strb(in_addr_q,  reg_req_i.wdata, reg_req_i.wstrb);
            if (ok_wr && offs == IN_SIZE_OFFS)  in_size_q  <= apply_strb(in_size_q,  reg_req_i.wdata, reg_req_i.wstrb);
            if (ok_wr && offs == OUT_ADDR_OFFS) out_addr_q <= apply_strb(out_addr_q, reg_req_i.wdata, reg_req_i.wstrb);
            if (ok_wr && offs == OUT_SIZE_OFFS) out_size_q <= apply_strb(out_size_q, reg_req_i.wdata, reg_req_i.wstrb);
        end

    assign reg_rsp_o.rdata = rdata_q;
    assign reg_rsp_o.error = err_q;
    assign reg_rsp_o.ready = ready_q;
    assign start_o    = start_q;
    assign busy_o     = state == RUN;
    assign irq_o      = irq_q;
    assign in_addr_o  = in_addr_q;
    assign in_size_o  = in_size_q;
    assign out_addr_o = out_addr_q;
    assign out_size_o = out_size_q;
endmodule
